// File: rtl/riscv_mmio_uart_tx.sv
// MMIO UART transmitter: stores to BASE_ADDR queue a byte in a small FIFO; an FSM shifts it out 8N1.
// Defining UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module riscv_mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          FIFO_AW      = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        TxD,
  output logic        TxBusy,
  output logic        FifoFull,
  output logic        FifoEmpty,
  output logic [7:0]  DropCount
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]  DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               hit;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [7:0]         head;
  logic               unused_wdata;

  assign hit          = MemWrite && (DataAdr == BASE_ADDR);
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign push         = hit && !full;
  assign head         = mem[rd_ptr];
  assign unused_wdata = ^WriteData[31:8];

  assign FifoFull  = full;
  assign FifoEmpty = empty;

  // A full FIFO drops the write even when the FSM pops in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      DropCount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (hit && full && (DropCount != 8'hFF)) DropCount <= DropCount + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= WriteData[7:0];
  end

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              baud_end;

`ifdef UART_TX_PARITY_EN
  logic par_q;

  // Parity is latched from the whole byte at pop time, before shifting destroys it.
  always_ff @(posedge CLK) begin
    if (RST)      par_q <= 1'b0;
    else if (pop) par_q <= ^head;
  end
`endif

  assign baud_end = (baud_q == BAUD_LAST);
  assign TxD      = txd_q;
  assign TxBusy   = (state_q != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd_d   = 1'b1;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = par_q;
`endif
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// Directed bench for riscv_mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_riscv_mmio_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        TxD;
  logic        TxBusy;
  logic        FifoFull;
  logic        FifoEmpty;
  logic [7:0]  DropCount;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  riscv_mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_0100),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4),
    .FIFO_AW     (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .MemWrite (MemWrite),
    .DataAdr  (DataAdr),
    .WriteData(WriteData),
    .TxD      (TxD),
    .TxBusy   (TxBusy),
    .FifoFull (FifoFull),
    .FifoEmpty(FifoEmpty),
    .DropCount(DropCount)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one store for exactly one edge; back-to-back calls give consecutive stores.
  task automatic store(input logic [31:0] adr, input logic [31:0] dat);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = dat;
    tick();
    MemWrite  = 1'b0;
  endtask

  // Checks TxD/TxBusy every cycle from frame cycle k0 to the end; par is the hand-computed parity bit.
  task automatic check_frame(input logic [7:0] b, input logic par, input int k0);
    logic [10:0] bits;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, par, b, 1'b0};
`else
    bits = {par, 1'b1, b, 1'b0};
`endif
    for (int k = k0; k < FRAME; k++) begin
      check($sformatf("txd_%02h_k%0d", b, k), TxD, bits[k / CPB]);
      check($sformatf("busy_%02h_k%0d", b, k), TxBusy, 1'b1);
      tick();
    end
  endtask

  initial begin
    int zeros;
    int busy;

    RST       = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    tick();
    tick();
    check("rst_txd", TxD, 1'b1);
    check("rst_busy", TxBusy, 1'b0);
    check("rst_empty", FifoEmpty, 1'b1);
    check("rst_full", FifoFull, 1'b0);
    check("rst_drop", DropCount, 8'h00);
    RST = 1'b0;
    tick();

    // Single byte 0xA5: FIFO non-empty after the store edge, start bit one edge later.
    store(32'h100, 32'h0000_00A5);
    check("single_empty_n", FifoEmpty, 1'b0);
    check("single_txd_n", TxD, 1'b1);
    check("single_busy_n", TxBusy, 1'b0);
    tick();
    check("single_empty_pop", FifoEmpty, 1'b1);
    check_frame(8'hA5, 1'b0, 0);
    check("single_busy_end", TxBusy, 1'b0);
    check("single_txd_end", TxD, 1'b1);
    check("single_empty_end", FifoEmpty, 1'b1);

    // Address misses.
    store(32'h104, 32'h55);
    check("miss104_empty", FifoEmpty, 1'b1);
    store(32'h0FF, 32'h55);
    check("miss0ff_empty", FifoEmpty, 1'b1);
    tick();
    tick();
    check("miss_txd", TxD, 1'b1);
    check("miss_busy", TxBusy, 1'b0);
    check("miss_empty", FifoEmpty, 1'b1);
    check("miss_drop", DropCount, 8'h00);

    // Overflow: 0x11 popped at once, 0x12..0x15 queued, 0x16 dropped. Now 4 cycles into frame 0x11.
    for (int i = 0; i < 6; i++) store(32'h100, 32'h11 + i);
    check("ovf_full", FifoFull, 1'b1);
    check("ovf_drop", DropCount, 8'h01);
    check_frame(8'h11, 1'b0, 4);
    check_frame(8'h12, 1'b0, 0);
    check_frame(8'h13, 1'b1, 0);
    check_frame(8'h14, 1'b0, 0);
    check_frame(8'h15, 1'b1, 0);
    check("ovf_busy_end", TxBusy, 1'b0);
    check("ovf_empty_end", FifoEmpty, 1'b1);
    check("ovf_txd_end", TxD, 1'b1);

    // DropCount saturation.
    for (int i = 0; i < 5; i++) store(32'h100, 32'h20 + i);
    check("sat_full", FifoFull, 1'b1);
    for (int i = 0; i < 300; i++) store(32'h100, 32'h30);
    check("sat_drop", DropCount, 8'hFF);

    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst2_drop", DropCount, 8'h00);
    check("rst2_empty", FifoEmpty, 1'b1);
    check("rst2_busy", TxBusy, 1'b0);
    check("rst2_txd", TxD, 1'b1);

    // Mid-frame reset during data bit 3 of 0x41 with 0x42, 0x43 queued.
    store(32'h100, 32'h41);
    store(32'h100, 32'h42);
    store(32'h100, 32'h43);
    check("mid_queued_empty", FifoEmpty, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    check("mid_bit3_txd", TxD, 1'b0);
    check("mid_bit3_busy", TxBusy, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_rst_txd", TxD, 1'b1);
    check("mid_rst_busy", TxBusy, 1'b0);
    check("mid_rst_empty", FifoEmpty, 1'b1);
    zeros = 0;
    busy  = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (TxD !== 1'b1) zeros++;
      if (TxBusy !== 1'b0) busy++;
    end
    check("mid_after_txd_low_cycles", zeros, 0);
    check("mid_after_busy_cycles", busy, 0);

`ifdef UART_TX_PARITY_EN
    store(32'h100, 32'h07);
    tick();
    check_frame(8'h07, 1'b1, 0);
    check("par07_busy_end", TxBusy, 1'b0);
    store(32'h100, 32'h03);
    tick();
    check_frame(8'h03, 1'b0, 0);
    check("par03_busy_end", TxBusy, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
